// File: rtl/uart_pkg.sv
// Shared UART-side types: data width and the transmit drain FSM states.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; a pop and a push each take effect on the next edge.
// Backpressure: a push is ignored when full and a pop is ignored when empty; the caller gates both.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage has no reset: a zero level already marks every entry as stale.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue ahead of the UART transmitter; a push into an empty queue launches two edges later.
// Backpressure: wr_ready drops at DEPTH entries; the drain waits for tx_busy low before each launch.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  output logic                    tx_enable,
  output logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    tx_error
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  tx_drain_state_t       state;
  tx_drain_state_t       state_nxt;
  logic [CW-1:0]         cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] head_data;

  // Full is taken from the registered level, so a same-cycle pop never frees a slot.
  assign wr_ready  = ~fifo_full;
  assign push      = wr_valid & wr_ready;
  assign tx_enable = (state == LAUNCH);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (head_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_clr   = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A byte whose frame never starts is dropped rather than retried.
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_data  <= '0;
      overflow <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)                cnt      <= '0;
      else if (cnt_inc)           cnt      <= cnt + 1'b1;
      if (pop)                    tx_data  <= head_data;
      if (wr_valid && fifo_full)  overflow <= 1'b1;
      if (err_set)                tx_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model and a responding UART, compared on every falling edge.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int T     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       tx_enable;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] level;
  logic       overflow;
  logic       tx_error;

  logic       uart_busy = 1'b0;
  logic       ext_busy = 1'b0;
  logic       uart_mute = 1'b0;
  int         busy_len = 10;
  int         bcnt = 0;
  logic [7:0] seen_q[$];

  int n_checks = 0;
  int n_pass = 0;

  assign tx_busy = uart_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH   (8),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .level     (level),
    .overflow  (overflow),
    .tx_error  (tx_error)
  );

  // UART stand-in: raises busy the cycle after enable and holds it busy_len cycles.
  always @(posedge clk) begin
    if (tx_enable) seen_q.push_back(tx_data);
    if (tx_enable && !uart_mute) begin
      uart_busy <= 1'b1;
      bcnt      <= busy_len;
    end else if (bcnt > 0) begin
      if (bcnt == 1) uart_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  // Reference model: byte queue plus "edges since launch" for the frame in progress.
  logic [7:0] mq[$];
  logic [7:0] mexp[$];
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 0;
  bit         m_err = 0;
  bit         m_active = 0;
  bit         m_got = 0;
  int         m_age = 0;
  int         m_n = 0;
  bit         model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_data   = 8'h00;
      m_ovf    = 0;
      m_err    = 0;
      m_active = 0;
      model_ok = 1;
    end else begin
      m_n = mq.size();
      if (!m_active) begin
        if (m_n != 0 && !tx_busy) begin
          m_data = mq.pop_front();
          mexp.push_back(m_data);
          m_active = 1;
          m_age    = 0;
          m_got    = 0;
        end
      end else begin
        m_age++;
        if (m_age >= 2) begin
          if (!m_got) begin
            if (tx_busy) m_got = 1;
            else if (m_age - 1 == T) begin
              m_err    = 1;
              m_active = 0;
            end
          end else if (!tx_busy) begin
            m_active = 0;
          end
        end
      end
      if (wr_valid) begin
        if (m_n == DEPTH) m_ovf = 1;
        else mq.push_back(wr_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("level", 32'(level), 32'(mq.size()));
      check("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
      check("tx_enable", 32'(tx_enable), 32'(m_active && m_age == 0));
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("tx_error", 32'(tx_error), 32'(m_err));
      check("enable_while_busy", 32'(tx_enable && tx_busy), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_enable) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int  base;
  int  rate;
  bit  ok;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_flags", 32'({overflow, tx_error, tx_enable}), 32'd0);

    // Single byte: launch two edges after the push, data held through the frame.
    tick();
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    check("t1_level_after_push", 32'(level), 32'd1);
    check("t1_no_enable_yet", 32'(tx_enable), 32'd0);
    @(negedge clk);
    check("t1_enable", 32'(tx_enable), 32'd1);
    check("t1_data", 32'(tx_data), 32'hA5);
    repeat (3) @(negedge clk);
    check("t1_busy_seen", 32'(tx_busy), 32'd1);
    check("t1_data_hold", 32'(tx_data), 32'hA5);
    repeat (15) @(negedge clk);
    check("t1_level_drained", 32'(level), 32'd0);
    check("t1_uart_byte", 32'(seen_q[seen_q.size()-1]), 32'hA5);

    // Fill while the UART reports busy, then overrun by one.
    busy_len = 3;
    base = seen_q.size();
    tick();
    ext_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    @(negedge clk);
    check("t2_full_level", 32'(level), 32'd16);
    check("t2_wr_ready_low", 32'(wr_ready), 32'd0);
    check("t2_no_overflow", 32'(overflow), 32'd0);
    wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_level", 32'(level), 32'd16);
    tick();
    ext_busy = 1'b0;
    repeat (250) @(negedge clk);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t2_count", 32'(seen_q.size() - base), 32'd16);
    for (int i = 0; i < 16 && base + i < seen_q.size(); i++)
      check("t2_order", 32'(seen_q[base+i]), 32'(i));

    // Silent UART: error exactly T cycles after the launch cycle, next byte follows.
    tick();
    uart_mute = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_valid = 1'b0;
    wait_enable(10, ok);
    check("t4_launch_seen", 32'(ok), 32'd1);
    check("t4_first_data", 32'(tx_data), 32'h11);
    repeat (T) @(negedge clk);
    check("t4_no_error_yet", 32'(tx_error), 32'd0);
    @(negedge clk);
    check("t4_error", 32'(tx_error), 32'd1);
    @(negedge clk);
    check("t4_next_launch", 32'(tx_enable), 32'd1);
    check("t4_next_data", 32'(tx_data), 32'h22);
    repeat (2 * T + 10) @(negedge clk);
    tick();
    uart_mute = 1'b0;

    // Random traffic with random frame lengths.
    rate = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) rate = $urandom_range(10, 90);
      wr_valid = ($urandom_range(0, 99) < rate);
      wr_data  = 8'($urandom);
      busy_len = $urandom_range(1, 12);
      tick();
    end
    wr_valid = 1'b0;
    repeat (400) @(negedge clk);
    check("rand_drained", 32'(level), 32'd0);

    // Reset in the middle of a frame with bytes still queued.
    tick();
    busy_len = 20;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hB0 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("t5_level_before", 32'(level), 32'd5);
    check("t5_busy_before", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_level", 32'(level), 32'd0);
    check("t5_enable", 32'(tx_enable), 32'd0);
    check("t5_data", 32'(tx_data), 32'd0);
    check("t5_flags", 32'({overflow, tx_error}), 32'd0);
    check("t5_wr_ready", 32'(wr_ready), 32'd1);
    base = seen_q.size();
    repeat (40) @(negedge clk);
    check("t5_no_launch", 32'(seen_q.size()), 32'(base));

    check("launch_count", 32'(seen_q.size()), 32'(mexp.size()));
    for (int i = 0; i < seen_q.size() && i < mexp.size(); i++)
      check("launch_byte", 32'(seen_q[i]), 32'(mexp[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
